// File: rtl/calc_pkg.sv
// Shared definitions for the calculator arithmetic sequencer.
// Op codes share their encoding with the key/state controller (calcul).
// Sequencer state encodings are used by calc_alu_seq.
package calc_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_MUL  = 3'd2,
    S_DIV  = 3'd3,
    S_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/calc_iter_dp.sv
// Iterative datapath for shift-add multiply and restoring divide.
// Latency: one step per cycle, W steps per operation; the step's next values are
//          exposed combinationally so the controller can capture the final step.
// Backpressure: none; the controller drives i_init/i_step directly.
// Ports:
//   clk, rst        clock and synchronous active-high reset (clears all regs)
//   i_init          load operands, clear accumulator, counter = W-1
//   i_step          perform one iteration (mode chosen by i_div)
//   i_div           1 = divide step, 0 = multiply step
//   i_a, i_b        operands (multiplier/dividend, multiplicand/divisor)
//   o_last          counter at zero: the current step is the final one
//   o_prod_nxt      product after the current multiply step
//   o_quot_nxt      quotient after the current divide step
//   o_rem_nxt       partial remainder after the current divide step
module calc_iter_dp #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_init,
  input  logic           i_step,
  input  logic           i_div,
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  output logic           o_last,
  output logic [2*W-1:0] o_prod_nxt,
  output logic [W-1:0]   o_quot_nxt,
  output logic [W-1:0]   o_rem_nxt
);

  localparam int CW = $clog2(W);

  // r_acc: upper product half (mul) or partial remainder (div).
  // r_q:   multiplier shifting out LSB first (mul) or dividend shifting out
  //        MSB first while quotient bits shift in at the bottom (div).
  logic [W-1:0]  r_acc;
  logic [W-1:0]  r_q;
  logic [W-1:0]  r_b;
  logic [CW-1:0] r_cnt;

  logic [W:0]    w_madd;
  logic [W:0]    w_shift;
  logic          w_ge;
  logic [W-1:0]  w_diff;
  logic [W-1:0]  w_acc_div;
  logic [W-1:0]  w_q_div;

  // Multiply: add multiplicand into the upper half when the current
  // multiplier bit is set, then shift the whole {carry, acc, q} right.
  assign w_madd     = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : '0);
  assign o_prod_nxt = {w_madd, r_q[W-1:1]};

  // Divide: bring in the next dividend bit; the shifted value is below 2*b,
  // so when it is >= b the difference always fits in W bits.
  assign w_shift    = {r_acc, r_q[W-1]};
  assign w_ge       = (w_shift >= {1'b0, r_b});
  assign w_diff     = w_shift[W-1:0] - r_b;
  assign w_acc_div  = w_ge ? w_diff : w_shift[W-1:0];
  assign w_q_div    = {r_q[W-2:0], w_ge};
  assign o_quot_nxt = w_q_div;
  assign o_rem_nxt  = w_acc_div;

  assign o_last = (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_q   <= '0;
      r_b   <= '0;
      r_cnt <= '0;
    end else if (i_init) begin
      r_acc <= '0;
      r_q   <= i_a;
      r_b   <= i_b;
      r_cnt <= CW'(W - 1);
    end else if (i_step) begin
      if (i_div) begin
        r_acc <= w_acc_div;
        r_q   <= w_q_div;
      end else begin
        r_acc <= w_madd[W:1];
        r_q   <= {w_madd[0], r_q[W-1:1]};
      end
      r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/calc_alu_seq.sv
// Multi-cycle arithmetic sequencer: add/sub in one compute cycle, mul/div iterative.
// Latency: add/sub/div-by-zero done 2 cycles after start; mul/div done W+2 cycles after.
// Backpressure: start is only sampled in IDLE; starts while busy/done are dropped.
// Ports:
//   clk, rst, esc   clock, synchronous active-high reset, synchronous abort
//   start, op, a, b request; operands and op latched on accepted start
//   busy, done      busy from cycle after accept through DONE; done one-cycle pulse
//   result, rem     2W-bit result (sum/|diff|/product/quotient), divide remainder
//   neg, err        sub a<b flag, divide-by-zero flag
module calc_alu_seq
  import calc_pkg::*;
#(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           esc,
  input  logic           start,
  input  logic [1:0]     op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] result,
  output logic [W-1:0]   rem,
  output logic           neg,
  output logic           err
);

  state_t         r_state;
  logic [1:0]     r_op;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;

  logic           w_clr;
  logic           w_init;
  logic           w_step;
  logic           w_last;
  logic [2*W-1:0] w_prod_nxt;
  logic [W-1:0]   w_quot_nxt;
  logic [W-1:0]   w_rem_nxt;
  logic [W:0]     w_sum;
  logic [W-1:0]   w_a_minus_b;
  logic [W-1:0]   w_b_minus_a;

  // ESC behaves exactly like reset, including the datapath registers.
  assign w_clr  = rst | esc;
  // Initialising in LOAD for every op is harmless for add/sub and saves decode.
  assign w_init = (r_state == S_LOAD);
  assign w_step = (r_state == S_MUL) || (r_state == S_DIV);

  assign w_sum       = {1'b0, r_a} + {1'b0, r_b};
  assign w_a_minus_b = r_a - r_b;
  assign w_b_minus_a = r_b - r_a;

  calc_iter_dp #(.W(W)) u_dp (
    .clk        (clk),
    .rst        (w_clr),
    .i_init     (w_init),
    .i_step     (w_step),
    .i_div      (r_state == S_DIV),
    .i_a        (r_a),
    .i_b        (r_b),
    .o_last     (w_last),
    .o_prod_nxt (w_prod_nxt),
    .o_quot_nxt (w_quot_nxt),
    .o_rem_nxt  (w_rem_nxt)
  );

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_state <= S_IDLE;
      r_op    <= OP_ADD;
      r_a     <= '0;
      r_b     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      rem     <= '0;
      neg     <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_op    <= op;
            r_a     <= a;
            r_b     <= b;
            busy    <= 1'b1;
            // Flags of the previous result are dropped as soon as a new
            // operation begins; result itself holds until the new DONE.
            rem     <= '0;
            neg     <= 1'b0;
            err     <= 1'b0;
            r_state <= S_LOAD;
          end
        end

        S_LOAD: begin
          case (r_op)
            OP_ADD: begin
              result  <= {{(W-1){1'b0}}, w_sum};
              done    <= 1'b1;
              r_state <= S_DONE;
            end
            OP_SUB: begin
              if (r_a >= r_b) begin
                result <= {{W{1'b0}}, w_a_minus_b};
                neg    <= 1'b0;
              end else begin
                result <= {{W{1'b0}}, w_b_minus_a};
                neg    <= 1'b1;
              end
              done    <= 1'b1;
              r_state <= S_DONE;
            end
            OP_MUL: begin
              r_state <= S_MUL;
            end
            default: begin
              if (r_b == '0) begin
                err     <= 1'b1;
                result  <= '0;
                rem     <= '0;
                done    <= 1'b1;
                r_state <= S_DONE;
              end else begin
                r_state <= S_DIV;
              end
            end
          endcase
        end

        // Final step's results are taken from the datapath's next-value
        // outputs so DONE is entered on the same edge as the last iteration.
        S_MUL: begin
          if (w_last) begin
            result  <= w_prod_nxt;
            done    <= 1'b1;
            r_state <= S_DONE;
          end
        end

        S_DIV: begin
          if (w_last) begin
            result  <= {{W{1'b0}}, w_quot_nxt};
            rem     <= w_rem_nxt;
            done    <= 1'b1;
            r_state <= S_DONE;
          end
        end

        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calc_alu_seq.sv
// Self-checking bench for calc_alu_seq (W=16): directed cases and random ops
// compared against an arithmetic reference model.
module tb_calc_alu_seq;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          esc;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          busy;
  logic          done;
  logic [2*W-1:0] result;
  logic [W-1:0]  rem;
  logic          neg;
  logic          err;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  calc_alu_seq #(.W(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .esc    (esc),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .rem    (rem),
    .neg    (neg),
    .err    (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation at the current negedge (cycle 0), follow it to its done
  // pulse and check timing and outputs against plain arithmetic. Optionally
  // pulse start again at cycle glitch_cyc while the op is in flight.
  // Returns at the negedge of the cycle after done (next start may go here).
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input int glitch_cyc);
    logic [31:0] e_res;
    logic [31:0] e_rem;
    logic        e_neg;
    logic        e_err;
    int          e_lat;
    int          c;
    logic        seen;
    e_rem = 0; e_neg = 0; e_err = 0; e_lat = 2;
    case (o)
      2'b00: e_res = 32'(x) + 32'(y);
      2'b01: begin
        e_neg = (x < y);
        e_res = e_neg ? 32'(y) - 32'(x) : 32'(x) - 32'(y);
      end
      2'b10: begin e_res = 32'(x) * 32'(y); e_lat = W + 2; end
      default: begin
        if (y == 0) begin
          e_res = 0; e_err = 1;
        end else begin
          e_res = 32'(x / y); e_rem = 32'(x % y); e_lat = W + 2;
        end
      end
    endcase

    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);               // cycle 1
    start = 1'b0;
    chk("busy_cycle1", 32'(busy), 32'd1);
    c = 1; seen = 1'b0;
    while (c <= 40) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      // Scrambled inputs while busy must not affect the latched operation.
      start = (c == glitch_cyc);
      op = 2'($urandom); a = W'($urandom); b = W'($urandom);
      @(negedge clk);
      c++;
    end
    start = 1'b0;
    chk("done_seen",  32'(seen),   32'd1);
    chk("latency",    32'(c),      32'(e_lat));
    chk("result",     result,      e_res);
    chk("rem",        32'(rem),    e_rem);
    chk("neg",        32'(neg),    32'(e_neg));
    chk("err",        32'(err),    32'(e_err));
    chk("busy_done",  32'(busy),   32'd1);
    @(negedge clk);
    chk("busy_after", 32'(busy),   32'd0);
    chk("done_pulse", 32'(done),   32'd0);
    chk("result_hold", result,     e_res);
  endtask

  initial begin
    int ndone;
    rst = 1'b1; esc = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy",   32'(busy),   32'd0);
    chk("rst_done",   32'(done),   32'd0);
    chk("rst_result", result,      32'd0);
    chk("rst_rem",    32'(rem),    32'd0);
    chk("rst_neg",    32'(neg),    32'd0);
    chk("rst_err",    32'(err),    32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases
    run_op(2'b00, 16'd1234,  16'd4321,  0);
    run_op(2'b00, 16'd65535, 16'd1,     0);
    run_op(2'b01, 16'd5,     16'd9,     0);
    run_op(2'b01, 16'd9,     16'd5,     0);
    run_op(2'b10, 16'd300,   16'd300,   0);
    run_op(2'b10, 16'd65535, 16'd65535, 0);
    run_op(2'b11, 16'd100,   16'd7,     0);
    run_op(2'b11, 16'd5,     16'd0,     0);
    run_op(2'b11, 16'd65535, 16'd1,     0);

    // Start pulse at cycle 3 of a multiply is ignored; the next run_op
    // starts in the cycle right after done and must be accepted.
    run_op(2'b10, 16'd1234, 16'd567, 3);
    run_op(2'b00, 16'd7,    16'd8,   0);
    run_op(2'b10, 16'd4321, 16'd99,  0);

    // ESC at cycle 5 of a multiply: aborts, clears outputs, no done pulse.
    op = 2'b10; a = 16'd300; b = 16'd300; start = 1'b1;
    @(negedge clk);               // cycle 1
    start = 1'b0;
    repeat (4) @(negedge clk);    // cycle 5
    esc = 1'b1;
    @(negedge clk);               // cycle 6
    esc = 1'b0;
    chk("esc_busy",   32'(busy), 32'd0);
    chk("esc_done",   32'(done), 32'd0);
    chk("esc_result", result,    32'd0);
    chk("esc_rem",    32'(rem),  32'd0);
    ndone = 0;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    chk("esc_no_done", 32'(ndone), 32'd0);

    // ESC together with start: request is overridden, sequencer stays idle.
    op = 2'b00; a = 16'd1; b = 16'd2; start = 1'b1; esc = 1'b1;
    @(negedge clk);
    start = 1'b0; esc = 1'b0;
    chk("escstart_busy", 32'(busy), 32'd0);
    ndone = 0;
    repeat (4) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    chk("escstart_no_done", 32'(ndone), 32'd0);
    chk("escstart_idle",    32'(busy),  32'd0);

    // Random operations
    for (int i = 0; i < 24; i++) begin
      logic [1:0]   ro;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ro = 2'($urandom);
      ra = W'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = '0;
        1:       rb = W'($urandom_range(1, 15));
        default: rb = W'($urandom);
      endcase
      run_op(ro, ra, rb, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
